// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_arbiter
//  Purpose  : Two-port arbiter in front of a single vector data memory.
//             Port 0 (vector pipeline) and port 1 (host loader) compete for
//             one access per cycle; the granted port's command is forwarded
//             combinationally and read data comes back one cycle later.
//  Macro    : DATA_MEM_ARB_ROUND_ROBIN_EN
//             defined   -> round-robin with bounded bursts (maxBurst)
//             undefined -> fixed priority, port 0 always wins contention
//  Ports    : clk, reset            clock / synchronous active-high reset
//             req0/1, we0/1         request, write enable per port
//             addr0/1, wdata0/1     byte address, vecSize lanes of write data
//             gnt0/1                access accepted this cycle
//             rvalid0/1, rdata0/1   read return, one cycle after read grant
//             mem_we/addr/wdata     command to memory (zero when no grant)
//             mem_rdata             registered memory read data
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_arbiter #(
  parameter int dataSize       = 32,
  parameter int addressingSize = 32,
  parameter int vecSize        = 4,
  parameter int maxBurst       = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req0,
  input  logic                         req1,
  input  logic                         we0,
  input  logic                         we1,
  input  logic [addressingSize-1:0]    addr0,
  input  logic [addressingSize-1:0]    addr1,
  input  logic [vecSize*dataSize-1:0]  wdata0,
  input  logic [vecSize*dataSize-1:0]  wdata1,
  output logic                         gnt0,
  output logic                         gnt1,
  output logic                         rvalid0,
  output logic                         rvalid1,
  output logic [vecSize*dataSize-1:0]  rdata0,
  output logic [vecSize*dataSize-1:0]  rdata1,
  output logic                         mem_we,
  output logic [addressingSize-1:0]    mem_addr,
  output logic [vecSize*dataSize-1:0]  mem_wdata,
  input  logic [vecSize*dataSize-1:0]  mem_rdata
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_OWN0 = 2'd1;
  localparam logic [1:0] c_OWN1 = 2'd2;

  logic [1:0] r_state;
  logic       w_gnt0;
  logic       w_gnt1;

`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
  localparam int                 c_CNT_W     = $clog2(maxBurst + 1);
  localparam logic [c_CNT_W-1:0] c_MAX_BURST = c_CNT_W'(maxBurst);

  logic               r_last_owner;
  logic [c_CNT_W-1:0] r_burst_cnt;
  logic               w_same_owner;
`endif

  // --------------------------------------------------------------------------
  // Grant selection
  // --------------------------------------------------------------------------
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!reset) begin
      if (req0 && !req1) begin
        w_gnt0 = 1'b1;
      end else if (req1 && !req0) begin
        w_gnt1 = 1'b1;
      end else if (req0 && req1) begin
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
        case (r_state)
          c_OWN0:  if (r_burst_cnt >= c_MAX_BURST) w_gnt1 = 1'b1; else w_gnt0 = 1'b1;
          c_OWN1:  if (r_burst_cnt >= c_MAX_BURST) w_gnt0 = 1'b1; else w_gnt1 = 1'b1;
          // From IDLE the port that did not own last time wins.
          default: if (r_last_owner) w_gnt0 = 1'b1; else w_gnt1 = 1'b1;
        endcase
`else
        // Port 0 wins every contention, preempting even a port-1 owner.
        case (r_state)
          c_OWN1:  w_gnt0 = 1'b1;
          default: w_gnt0 = 1'b1;
        endcase
`endif
      end
    end
  end

  assign gnt0 = w_gnt0;
  assign gnt1 = w_gnt1;

  // --------------------------------------------------------------------------
  // Memory command mux
  // --------------------------------------------------------------------------
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (w_gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  // --------------------------------------------------------------------------
  // Owner FSM: remembers who was granted in the previous cycle
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else if (w_gnt0) begin
      r_state <= c_OWN0;
    end else if (w_gnt1) begin
      r_state <= c_OWN1;
    end else begin
      r_state <= c_IDLE;
    end
  end

`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
  assign w_same_owner = (w_gnt0 && (r_state == c_OWN0)) ||
                        (w_gnt1 && (r_state == c_OWN1));

  always_ff @(posedge clk) begin
    if (reset) begin
      // last_owner = 1 lets port 0 win the first contention after reset.
      r_last_owner <= 1'b1;
      r_burst_cnt  <= '0;
    end else if (w_gnt0 || w_gnt1) begin
      r_last_owner <= w_gnt1;
      if (!w_same_owner) begin
        r_burst_cnt <= c_CNT_W'(1);
      end else if (r_burst_cnt != c_MAX_BURST) begin
        r_burst_cnt <= r_burst_cnt + c_CNT_W'(1);
      end
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Read return path
  // --------------------------------------------------------------------------
  logic                        r_rvalid0;
  logic                        r_rvalid1;
  logic                        w_rvalid0;
  logic                        w_rvalid1;
  logic [vecSize*dataSize-1:0] r_rdata0;
  logic [vecSize*dataSize-1:0] r_rdata1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt0 && !we0;
      r_rvalid1 <= w_gnt1 && !we1;
    end
  end

  // Masking with reset drops a return whose grant landed just before reset.
  assign w_rvalid0 = r_rvalid0 && !reset;
  assign w_rvalid1 = r_rvalid1 && !reset;

  // Capture the returned word so rdata holds once rvalid drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (w_rvalid0) r_rdata0 <= mem_rdata;
      if (w_rvalid1) r_rdata1 <= mem_rdata;
    end
  end

  assign rvalid0 = w_rvalid0;
  assign rvalid1 = w_rvalid1;
  assign rdata0  = w_rvalid0 ? mem_rdata : r_rdata0;
  assign rdata1  = w_rvalid1 ? mem_rdata : r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_arbiter
//  Purpose  : Directed-vector bench for data_mem_arbiter with a queue-based
//             scoreboard; includes a small registered memory model.
//  Macro    : DATA_MEM_ARB_ROUND_ROBIN_EN selects the expected grant pattern
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_arbiter;

  localparam int c_AW = 32;
  localparam int c_VW = 128;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [c_AW-1:0]   addr0 = '0, addr1 = '0;
  logic [c_VW-1:0]   wdata0 = '0, wdata1 = '0;
  logic              gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [c_VW-1:0]   rdata0, rdata1, mem_wdata;
  logic [c_VW-1:0]   mem_rdata = '0;
  logic [c_AW-1:0]   mem_addr;

  data_mem_arbiter #(.dataSize(32), .addressingSize(32), .vecSize(4), .maxBurst(4)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Registered memory: 64 words indexed by byte address [7:2].
  logic [c_VW-1:0] mem [64];
  initial begin
    for (int i = 0; i < 64; i++)
      for (int l = 0; l < 4; l++)
        mem[i][l*32 +: 32] = 32'hC0DE_0000 | (i << 4) | l;
  end
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:2]];
  end

  localparam logic [c_VW-1:0] W4 = {32'hC0DE0043, 32'hC0DE0042, 32'hC0DE0041, 32'hC0DE0040};
  localparam logic [c_VW-1:0] W5 = {32'hC0DE0053, 32'hC0DE0052, 32'hC0DE0051, 32'hC0DE0050};
  localparam logic [c_VW-1:0] WR = {32'hD, 32'hC, 32'hB, 32'hA};
  localparam logic [c_VW-1:0] D0 = {4{32'h1111_0000}};
  localparam logic [c_VW-1:0] D1 = {4{32'h2222_0000}};

  typedef struct {
    logic            g0, g1, we;
    logic [c_AW-1:0] addr;
    logic [c_VW-1:0] wdata;
    logic            rv0, rv1, c0, c1;
    logic [c_VW-1:0] rd0, rd1;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   n_cyc  = 0;

  // One cycle of stimulus plus its hand-derived expectation.
  task automatic step(input logic rst,
                      input logic r0, input logic w0, input logic [c_AW-1:0] a0, input logic [c_VW-1:0] d0,
                      input logic r1, input logic w1, input logic [c_AW-1:0] a1, input logic [c_VW-1:0] d1,
                      input logic eg0, input logic eg1, input logic erv0, input logic erv1,
                      input logic c0, input logic [c_VW-1:0] erd0,
                      input logic c1, input logic [c_VW-1:0] erd1);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    e.g0 = eg0; e.g1 = eg1;
    e.we    = eg0 ? w0 : (eg1 ? w1 : 1'b0);
    e.addr  = eg0 ? a0 : (eg1 ? a1 : '0);
    e.wdata = eg0 ? d0 : (eg1 ? d1 : '0);
    e.rv0 = erv0; e.rv1 = erv1; e.c0 = c0; e.c1 = c1; e.rd0 = erd0; e.rd1 = erd1;
    q.push_back(e);
  endtask

  // Monitor: pops one expectation for every cycle the DUT presents outputs.
  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cyc++;
        n_vec++;
        ok = (gnt0 === e.g0) && (gnt1 === e.g1) && (mem_we === e.we) &&
             (mem_addr === e.addr) && (mem_wdata === e.wdata) &&
             (rvalid0 === e.rv0) && (rvalid1 === e.rv1) &&
             (!e.c0 || rdata0 === e.rd0) && (!e.c1 || rdata1 === e.rd1);
        if (!ok) begin
          n_fail++;
          $display("FAIL vec%0d: got gnt=%b%b we=%b addr=%h rv=%b%b rd0=%h rd1=%h wd=%h | want gnt=%b%b we=%b addr=%h rv=%b%b rd0=%h rd1=%h wd=%h",
                   n_cyc, gnt0, gnt1, mem_we, mem_addr, rvalid0, rvalid1, rdata0, rdata1, mem_wdata,
                   e.g0, e.g1, e.we, e.addr, e.rv0, e.rv1, e.rd0, e.rd1, e.wdata);
        end
      end
    end
  end

  logic [9:0] pat;   // bit k = 1 -> port 1 expected granted in contention cycle k
  logic       pg, prv0, prv1;

  initial begin
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
    pat = 10'b00_1111_0000;
`else
    pat = 10'b00_0000_0000;
`endif
    // Reset with both ports requesting writes: nothing may get through.
    step(1, 1,1,32'h10,D0, 1,1,32'h14,D1, 0,0,0,0, 1,'0, 1,'0);
    step(1, 1,1,32'h10,D0, 1,1,32'h14,D1, 0,0,0,0, 1,'0, 1,'0);
    // Single port-0 read, return next cycle, then hold.
    step(0, 1,0,32'h10,D0, 0,0,'0,'0,     1,0,0,0, 1,'0, 1,'0);
    step(0, 0,0,'0,'0,     0,0,'0,'0,     0,0,1,0, 1,W4, 1,'0);
    step(0, 0,0,'0,'0,     0,0,'0,'0,     0,0,0,0, 1,W4, 1,'0);
    // Back-to-back port-1 reads, second one misaligned.
    step(0, 0,0,'0,'0,     1,0,32'h14,D1, 0,1,0,0, 1,W4, 1,'0);
    step(0, 0,0,'0,'0,     1,0,32'h13,D1, 0,1,0,1, 1,W4, 1,W5);
    step(0, 0,0,'0,'0,     0,0,'0,'0,     0,0,0,1, 1,W4, 1,W4);
    step(0, 0,0,'0,'0,     0,0,'0,'0,     0,0,0,0, 1,W4, 1,W4);
    // Port-1 write of lanes A..D, then port-0 read of the same word.
    step(0, 0,0,'0,'0,     1,1,32'h20,WR, 0,1,0,0, 1,W4, 1,W4);
    step(0, 1,0,32'h20,D0, 0,0,'0,'0,     1,0,0,0, 1,W4, 1,W4);
    step(0, 0,0,'0,'0,     0,0,'0,'0,     0,0,1,0, 1,WR, 1,W4);
    // Read granted, then reset: its return must be suppressed.
    step(0, 1,0,32'h10,D0, 0,0,'0,'0,     1,0,0,0, 1,WR, 1,W4);
    step(1, 1,0,32'h10,D0, 1,0,32'h14,D1, 0,0,0,0, 0,'0, 0,'0);
    step(1, 1,0,32'h10,D0, 1,0,32'h14,D1, 0,0,0,0, 1,'0, 1,'0);
    // Ten cycles of continuous contention, then one drain cycle.
    for (int k = 0; k < 11; k++) begin
      pg   = (k < 10) ? pat[k] : 1'b0;
      prv0 = (k > 0) && !pat[k-1];
      prv1 = (k > 0) &&  pat[k-1];
      if (k < 10)
        step(0, 1,0,32'h10,D0, 1,0,32'h14,D1, !pg,pg, prv0,prv1, prv0,W4, prv1,W5);
      else
        step(0, 0,0,'0,'0,     0,0,'0,'0,     0,0,    prv0,prv1, prv0,W4, prv1,W5);
    end
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter dataSize, default 32, width in bits of one vector lane.
REQ-002 SHALL have parameter addressingSize, default 32, width of the byte address.
REQ-003 SHALL have parameter vecSize, default 4, number of lanes per access.
REQ-004 SHALL have parameter maxBurst, default 4, maximum consecutive grants to one port while the other port is requesting.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have ports req0/req1, input, 1 bit each, access request from port 0 (vector pipeline) and port 1 (host loader).
REQ-008 SHALL have ports we0/we1, input, 1 bit each, 1 = write, 0 = read.
REQ-009 SHALL have ports addr0/addr1, input, addressingSize bits each, byte address.
REQ-010 SHALL have ports wdata0/wdata1, input, vecSize x dataSize each, write lanes.
REQ-011 SHALL have ports gnt0/gnt1, output, 1 bit each, access accepted this cycle.
REQ-012 SHALL have ports rvalid0/rvalid1, output, 1 bit each, read data valid.
REQ-013 SHALL have ports rdata0/rdata1, output, vecSize x dataSize each, read lanes.
REQ-014 SHALL have memory-side ports mem_we (out, 1), mem_addr (out, addressingSize), mem_wdata (out, vecSize x dataSize), mem_rdata (in, vecSize x dataSize).

Function
REQ-015 SHALL grant at most one port per cycle; gnt0 and gnt1 never high together.
REQ-016 SHALL drive gnt combinationally in the cycle a request is accepted; a request is consumed when req and gnt are both high.
REQ-017 SHALL drive mem_we, mem_addr and mem_wdata combinationally from the granted port; with no grant, mem_we = 0 and mem_addr/mem_wdata = 0.
REQ-018 SHALL use a three-state owner FSM: IDLE, OWN0 and OWN1; the FSM records the port granted in the previous cycle.
REQ-019 In IDLE, or with only one port requesting, SHALL grant the sole requester; with neither port requesting, the FSM SHALL return to IDLE.
REQ-020 On contention from IDLE, SHALL grant the port not recorded in last_owner.
REQ-021 On contention while OWNx, SHALL keep granting port x until burst_cnt reaches maxBurst, then grant the other port and reset burst_cnt to 1.
REQ-022 burst_cnt SHALL be $clog2(maxBurst+1) bits, SHALL increment on each consecutive grant to the same port, SHALL saturate at maxBurst, and SHALL reload to 1 on an owner change.
REQ-023 SHALL assert rvalidx exactly one cycle after a read grant to port x, matching the 1-cycle registered memory read latency; rdatax SHALL equal mem_rdata in that cycle.
REQ-024 SHALL support back-to-back reads: a grant in cycle N+1 coexists with rvalid for the cycle-N grant.
REQ-025 A write grant SHALL never produce rvalid.
REQ-026 rdatax SHALL hold its last valid value while rvalidx is 0.
REQ-027 A request with addr[1:0] != 0 (misaligned) SHALL still be arbitrated and forwarded unchanged; the memory ignores the low bits.

Reset
REQ-028 While reset is high at a clock edge: FSM = IDLE, last_owner = 1 (so port 0 wins the first contention), burst_cnt = 0, rvalid0/rvalid1 = 0, rdata0/rdata1 = 0.
REQ-029 During reset, gnt0, gnt1 and mem_we SHALL be 0 regardless of req.
REQ-030 A read granted in the cycle before reset asserts SHALL NOT produce rvalid after reset.

Configuration
REQ-031 Macro DATA_MEM_ARB_ROUND_ROBIN_EN: when defined, arbitration SHALL follow REQ-019..REQ-022.
REQ-032 When DATA_MEM_ARB_ROUND_ROBIN_EN is undefined, SHALL use fixed priority with port 0 always winning contention; burst_cnt and last_owner SHALL be absent, and port 1 may starve.

Verification
REQ-033 Reset high for 2 cycles with req0 = req1 = 1 -> gnt0 = gnt1 = 0, rvalid = 0, mem_we = 0.
REQ-034 Port 0 read addr 0x10 only -> gnt0 = 1 that cycle, mem_addr = 0x10, mem_we = 0; next cycle rvalid0 = 1 and rdata0 = mem_rdata.
REQ-035 Both ports request reads continuously for 10 cycles with round-robin enabled -> grant pattern 0,0,0,0,1,1,1,1,0,0.
REQ-036 Same stimulus with the macro undefined -> gnt0 = 1 for all 10 cycles, gnt1 = 0.
REQ-037 Port 1 writes 4 lanes 0xA..0xD to 0x20, then port 0 reads 0x20 -> mem_we = 1 for the write with no rvalid1; rvalid0 = 1 one cycle after the read grant with rdata0 = {0xD,0xC,0xB,0xA}.
REQ-038 Read granted in cycle N with reset asserted in cycle N+1 -> rvalid0 = 0 in cycle N+1 and after.
